// File: rtl/nibble_accumulate_ctrl.sv
// Valid/ready control stage that feeds an external 4-bit ripple-carry adder and accumulates bursts of N_OPS operands.
// Optional subtract support is enabled with the ACC_SUB_EN macro.
module nibble_accumulate_ctrl #(
    parameter int unsigned N_OPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
`ifdef ACC_SUB_EN
    input  logic       in_sub,
`endif
    output logic [3:0] adder_a,
    output logic [3:0] adder_b,
    output logic       adder_cin,
    input  logic [3:0] adder_s,
    input  logic       adder_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_ovf,
    output logic [3:0] out_count
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ADD    = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] acc, acc_n;
    logic [DW-1:0] op_reg, op_n;
    logic [DW-1:0] cnt, cnt_n, cnt_inc;
    logic          sub_reg, sub_n;
    logic          ovf, ovf_n;
    logic          in_sub_s;
    logic          in_ready_n, out_valid_n, adder_cin_n;
    logic [DW-1:0] adder_b_n;

`ifdef ACC_SUB_EN
    assign in_sub_s = in_sub;
`else
    assign in_sub_s = 1'b0;
`endif

    assign cnt_inc = DW'(cnt + DW'(1));

    // State and datapath registers; handshake and adder-drive outputs are registered alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCEPT;
            acc       <= '0;
            op_reg    <= '0;
            sub_reg   <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            adder_b   <= '0;
            adder_cin <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            op_reg    <= op_n;
            sub_reg   <= sub_n;
            ovf       <= ovf_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            adder_b   <= adder_b_n;
            adder_cin <= adder_cin_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n = state;
        acc_n   = acc;
        op_n    = op_reg;
        sub_n   = sub_reg;
        ovf_n   = ovf;
        cnt_n   = cnt;

        unique case (state)
            ACCEPT: begin
                if (in_valid) begin
                    op_n    = in_data;
                    sub_n   = in_sub_s;
                    state_n = ADD;
                end
            end
            ADD: begin
                acc_n   = adder_s;
                cnt_n   = cnt_inc;
                // Carry out on add, missing carry (borrow) on subtract
                ovf_n   = ovf | (sub_reg ? ~adder_cout : adder_cout);
                state_n = (cnt_inc == DW'(N_OPS)) ? RESULT : ACCEPT;
            end
            RESULT: begin
                if (out_ready) begin
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = ACCEPT;
                end
            end
            default: state_n = ACCEPT;
        endcase

        in_ready_n  = (state_n == ACCEPT);
        out_valid_n = (state_n == RESULT);
        adder_b_n   = (state_n == ADD) ? (sub_n ? ~op_n : op_n) : '0;
        adder_cin_n = (state_n == ADD) & sub_n;
    end

    assign adder_a   = acc;
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_nibble_accumulate_ctrl.sv
// Self-checking bench for nibble_accumulate_ctrl with a behavioural 4-bit adder and burst model.
// Subtract steps are exercised only when ACC_SUB_EN is defined.
module tb_nibble_accumulate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [3:0] in_data, adder_a, adder_b, adder_s, out_sum, out_count;
    logic       adder_cin, adder_cout;
`ifdef ACC_SUB_EN
    logic       in_sub;
`endif

    // Second instance for the single-operand burst boundary
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [3:0] in_data1, adder_a1, adder_b1, adder_s1, out_sum1, out_count1;
    logic       adder_cin1, adder_cout1;

    int checks = 0;
    int failures = 0;

    int m_acc, m_cnt;
    bit m_ovf;
    int ops[$];
    bit subs[$];

    always #5 clk = ~clk;

    assign {adder_cout, adder_s}   = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);
    assign {adder_cout1, adder_s1} = 5'(adder_a1) + 5'(adder_b1) + 5'(adder_cin1);

    nibble_accumulate_ctrl #(.N_OPS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef ACC_SUB_EN
        .in_sub(in_sub),
`endif
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_s(adder_s), .adder_cout(adder_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
    );

    nibble_accumulate_ctrl #(.N_OPS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
`ifdef ACC_SUB_EN
        .in_sub(1'b0),
`endif
        .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
        .adder_s(adder_s1), .adder_cout(adder_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1), .out_count(out_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        chk({tag, "_adder_a"}, 32'(adder_a), 32'd0);
        chk({tag, "_adder_b"}, 32'(adder_b), 32'd0);
        chk({tag, "_adder_cin"}, 32'(adder_cin), 32'd0);
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic drive_sub(input bit s);
`ifdef ACC_SUB_EN
        in_sub = s;
`else
        if (s) $display("note: subtract step requested in add-only build");
`endif
    endtask

    // Plays ops/subs as one burst; idle gaps between operands and RESULT backpressure in cycles
    task automatic run_burst(input int gap_min, input int gap_max, input int bp);
        int t;
        logic [3:0] exp_b;
        out_ready = (bp == 0);
        for (int i = 0; i < ops.size(); i++) begin
            int g = $urandom_range(gap_max, gap_min);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                @(negedge clk);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
                chk("idle_out_count", 32'(out_count), 32'(m_cnt));
                chk("idle_out_sum", 32'(out_sum), 32'(m_acc));
            end
            chk("accept_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = 4'(ops[i]);
            drive_sub(subs[i]);
            @(negedge clk);
            exp_b = subs[i] ? ~4'(ops[i]) : 4'(ops[i]);
            chk("add_in_ready", 32'(in_ready), 32'd0);
            chk("add_adder_a", 32'(adder_a), 32'(m_acc));
            chk("add_adder_b", 32'(adder_b), 32'(exp_b));
            chk("add_adder_cin", 32'(adder_cin), 32'(subs[i]));
            // Junk held on the input during ADD must not be taken
            in_data = 4'($urandom);
            drive_sub(1'b0);
            t = subs[i] ? m_acc - ops[i] : m_acc + ops[i];
            if (t > 15 || t < 0) m_ovf = 1;
            m_acc = t & 15;
            m_cnt++;
            @(negedge clk);
            chk("step_out_sum", 32'(out_sum), 32'(m_acc));
            chk("step_out_count", 32'(out_count), 32'(m_cnt));
            chk("step_out_ovf", 32'(out_ovf), 32'(m_ovf));
        end
        chk("result_out_valid", 32'(out_valid), 32'd1);
        chk("result_in_ready", 32'(in_ready), 32'd0);
        chk("result_adder_b", 32'(adder_b), 32'd0);
        if (bp > 0) begin
            repeat (bp) begin
                @(negedge clk);
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_out_sum", 32'(out_sum), 32'(m_acc));
                chk("hold_out_ovf", 32'(out_ovf), 32'(m_ovf));
                chk("hold_out_count", 32'(out_count), 32'(m_cnt));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        model_clear();
        chk_reset_outputs("post_result");
        ops.delete();
        subs.delete();
    endtask

    task automatic load(input int a, input int b, input int c, input int d,
                        input bit sa, input bit sb, input bit sc, input bit sd);
        ops  = '{a, b, c, d};
        subs = '{sa, sb, sc, sd};
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 4'd0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = 4'd0;
        out_ready1 = 1'b1;
        drive_sub(1'b0);
        model_clear();
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        // Three operands taken, reset lands during the ADD of the third
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(5 + i);
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 2) @(negedge clk);
        end
        chk("midburst_adder_b", 32'(adder_b), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midburst_reset");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        load(1, 1, 1, 1, 0, 0, 0, 0);
        run_burst(0, 0, 0);

        load(3, 5, 7, 2, 0, 0, 0, 0);
        run_burst(0, 0, 0);
        load(1, 2, 3, 4, 0, 0, 0, 0);
        run_burst(0, 0, 5);
        load(4, 4, 4, 4, 0, 0, 0, 0);
        run_burst(1, 1, 0);
`ifdef ACC_SUB_EN
        load(9, 4, 7, 2, 0, 1, 1, 0);
        run_burst(0, 0, 0);
`endif

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                ops.push_back(int'($urandom_range(15, 0)));
`ifdef ACC_SUB_EN
                subs.push_back(bit'($urandom_range(1, 0)));
`else
                subs.push_back(1'b0);
`endif
            end
            run_burst(0, 2, int'($urandom_range(3, 0)));
        end

        // Single-operand burst on the N_OPS=1 instance
        chk("n1_idle_in_ready", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        in_data1  = 4'd15;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("n1_add_adder_b", 32'(adder_b1), 32'd15);
        chk("n1_add_out_valid", 32'(out_valid1), 32'd0);
        @(negedge clk);
        chk("n1_out_valid", 32'(out_valid1), 32'd1);
        chk("n1_out_sum", 32'(out_sum1), 32'd15);
        chk("n1_out_ovf", 32'(out_ovf1), 32'd0);
        chk("n1_out_count", 32'(out_count1), 32'd1);
        @(negedge clk);
        chk("n1_post_out_valid", 32'(out_valid1), 32'd0);
        chk("n1_post_in_ready", 32'(in_ready1), 32'd1);
        chk("n1_post_out_count", 32'(out_count1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
